// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor, one BLOCK-bit group per stage.
// Valid/ready streaming with a full-pipeline stall; registered outputs.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH:0]   out
);
    localparam int NGRP = WIDTH / BLOCK;

    // Returns {carry out, carry into top bit, group sum}.
    // Every carry is a flat sum of products of g, p and c0.
    function automatic logic [BLOCK+1:0] cla_group(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             c0
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             t;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            t = c0;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                c[i+1] = c[i+1] | t;
            end
        end
        return {c[BLOCK], c[BLOCK-1], p ^ c[BLOCK-1:0]};
    endfunction

    logic [NGRP-1:0]  v_q, v_d;
    logic [NGRP-1:0]  c_q, c_d;
    logic [WIDTH-1:0] a_q [NGRP];
    logic [WIDTH-1:0] a_d [NGRP];
    logic [WIDTH-1:0] b_q [NGRP];
    logic [WIDTH-1:0] b_d [NGRP];
    logic [WIDTH-1:0] s_q [NGRP];
    logic [WIDTH-1:0] s_d [NGRP];
    logic [BLOCK+1:0] res [NGRP];

    logic [WIDTH-1:0] s_out_q, s_out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             vout_q, vout_d;
    logic             en;

    always_comb begin
        en       = !vout_q || out_ready;
        v_d[0]   = in_valid;
        a_d[0]   = A;
        b_d[0]   = sub ? ~B : B;
        s_d[0]   = '0;
        c_d[0]   = sub | cin;
        for (int r = 0; r < NGRP; r++) begin
            res[r] = cla_group(a_q[r][r*BLOCK +: BLOCK],
                               b_q[r][r*BLOCK +: BLOCK], c_q[r]);
        end
        for (int r = 1; r < NGRP; r++) begin
            v_d[r] = v_q[r-1];
            a_d[r] = a_q[r-1];
            b_d[r] = b_q[r-1];
            c_d[r] = res[r-1][BLOCK+1];
            s_d[r] = s_q[r-1];
            s_d[r][(r-1)*BLOCK +: BLOCK] = res[r-1][BLOCK-1:0];
        end
        vout_d  = v_q[NGRP-1];
        s_out_d = s_out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        // Only real beats load the outputs, so bubbles never leak X.
        if (v_q[NGRP-1]) begin
            s_out_d = s_q[NGRP-1];
            s_out_d[(NGRP-1)*BLOCK +: BLOCK] = res[NGRP-1][BLOCK-1:0];
            cout_d  = res[NGRP-1][BLOCK+1];
            ovf_d   = res[NGRP-1][BLOCK+1] ^ res[NGRP-1][BLOCK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            vout_q  <= 1'b0;
            s_out_q <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            v_q     <= v_d;
            vout_q  <= vout_d;
            s_out_q <= s_out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            c_q <= c_d;
            for (int r = 0; r < NGRP; r++) begin
                a_q[r] <= a_d[r];
                b_q[r] <= b_d[r];
                s_q[r] <= s_d[r];
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = vout_q;
    assign S         = s_out_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out       = {cout_q, s_out_q};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=16, BLOCK=4, latency 4).
// Table of hand-computed vectors, a result queue, and corner-case sequences.
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, sub;
    logic        out_valid, out_ready, cout, ovf;
    logic [15:0] A, B, S;
    logic [16:0] out;

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .cout(cout), .ovf(ovf), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } res_t;

    vec_t tbl [8];
    res_t exp_q [$];
    int   out_cyc [$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    int   stall_cnt = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    always @(posedge clk) ncyc++;

    always @(negedge clk) begin : mon
        res_t r;
        if (mon_en && out_valid) begin
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {31'd0, out_valid}, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("S", {16'd0, S}, {16'd0, r.s});
                    chk("cout", {31'd0, cout}, {31'd0, r.co});
                    chk("ovf", {31'd0, ovf}, {31'd0, r.ov});
                    chk("out", {15'd0, out}, {15'd0, r.co, r.s});
                    out_cyc.push_back(ncyc);
                end
            end else begin
                stall_cnt++;
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                if (exp_q.size() > 0)
                    chk("stall_S", {16'd0, S}, {16'd0, exp_q[0].s});
            end
        end
    end

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        bit acc;
        res_t r;
        acc      = 1'b0;
        in_valid = 1'b1;
        A        = v.a;
        B        = v.b;
        cin      = v.ci;
        sub      = v.sb;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc  = 1'b1;
                r.s  = v.s;
                r.co = v.co;
                r.ov = v.ov;
                exp_q.push_back(r);
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipeline; checks exact latency of 4.
    task automatic lat(input string nm, input vec_t v);
        in_valid = 1'b1;
        A        = v.a;
        B        = v.b;
        cin      = v.ci;
        sub      = v.sb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < 4) begin
                chk({nm, "_early"}, {31'd0, out_valid}, 32'd0);
            end else begin
                chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
                chk({nm, "_S"}, {16'd0, S}, {16'd0, v.s});
                chk({nm, "_cout"}, {31'd0, cout}, {31'd0, v.co});
                chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, v.ov});
                chk({nm, "_out"}, {15'd0, out}, {15'd0, v.co, v.s});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        vec_t v;
        tbl[0] = '{16'h0808, 16'h0808, 1'b1, 1'b0, 16'h1011, 1'b0, 1'b0};
        tbl[1] = '{16'h0C0C, 16'h0202, 1'b1, 1'b0, 16'h0E0F, 1'b0, 1'b0};
        tbl[2] = '{16'h0404, 16'h0707, 1'b0, 1'b0, 16'h0B0B, 1'b0, 1'b0};
        tbl[3] = '{16'hFFFF, 16'hFCFC, 1'b1, 1'b0, 16'hFCFC, 1'b1, 1'b0};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        A         = 16'h1111;
        B         = 16'h2222;
        cin       = 1'b0;
        sub       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_S", {16'd0, S}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_out", {15'd0, out}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        cnt      = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        chk("no_beat_after_rst", cnt, 32'd0);
        @(posedge clk);
        #1;

        v = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        lat("carry_chain", v);

        mon_en = 1'b1;
        out_cyc.delete();
        for (int i = 0; i < 5; i++) send(tbl[i]);
        in_valid = 1'b0;
        drain();
        chk("stream_count", out_cyc.size(), 32'd5);
        if (out_cyc.size() == 5)
            chk("stream_b2b", out_cyc[4] - out_cyc[0], 32'd4);

        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(tbl[i]);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_cycles", stall_cnt, 32'd3);

        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) send(tbl[i]);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        chk("midrst_flushed", cnt, 32'd0);
        @(posedge clk);
        #1;
        v = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        lat("after_midrst", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor: WIDTH-bit operands, split into BLOCK-bit CLA groups.
- One pipeline register stage per group; group carry crosses each stage boundary registered.
- Valid/ready streaming handshake with full-pipeline stall.
- Used as the arithmetic core wherever operand widths beyond 4 bits need a closed-timing adder.

Parameters:
- WIDTH, 16, operand/sum width; must be an integer multiple of BLOCK.
- BLOCK, 4, CLA group width (generate/propagate look-ahead inside a group); BLOCK >= 2.
- Derived NGRP = WIDTH/BLOCK = pipeline depth = latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts a beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1, cin ignored)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- S  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- out  output  WIDTH+1  {cout, S}

Behaviour:
- Pipeline advance enable: en = !out_valid || out_ready. in_ready = en (combinational).
- Beat accepted when in_valid && in_ready. When en=0, every stage register, including valid bits and skew registers, holds.
- Stage k (0..NGRP-1) computes group k: g = a&b, p = a^b; look-ahead carries c[i+1] = g[i] | p[i]&c[i], expanded in sum-of-products form within the group, with no ripple inside the group. Group carry-in is the registered carry from stage k-1; stage 0 carry-in is (sub ? 1 : cin).
- B is inverted at capture when sub=1. Operands for groups not yet processed travel through skew registers. Completed sum groups travel through de-skew registers so that all WIDTH bits of one beat emerge together.
- Latency: a beat accepted at edge t appears on out_valid/S/cout/ovf after edge t+NGRP, with no stall. Throughput is 1 beat/cycle.
- Beats never reorder, duplicate or drop. Each beat's result is a function of that beat's A, B, cin and sub only; there is no state carried between beats.
- Outputs are registered. They hold stable while out_valid && !out_ready.
- Reset: on the edge where rst=1, all stage valid bits clear to 0, and S, cout, ovf and out clear to 0; out_valid=0. in_ready reads 1 during and after reset, since out_valid=0. Reset mid-stream discards all in-flight beats. The first beat accepted after rst deasserts follows the normal latency.
- Data registers other than outputs need not reset, but X must never reach the outputs while out_valid=0 after reset; outputs read 0.
- Wrap-around: the sum is modulo 2^WIDTH. The carry is reported on cout only.
- Simultaneous events:
  - in_valid with a stall: the beat is not accepted; the source must hold.
  - Output consumed and a new beat accepted in the same cycle: permitted, and the pipeline stays full.
  - rst has priority over everything.

Test Plan (WIDTH=16, BLOCK=4, latency 4):
- Reset: hold rst for 2 cycles with in_valid=1 -> out_valid=0, S=0, cout=0, ovf=0, out=0, in_ready=1; no beat emerges afterwards.
- Full carry chain: A=FFFF, B=0001, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, S=0000, cout=1, ovf=0, out=10000.
- Streaming: push 5 back-to-back beats (0808+0808+1, 0C0C+0202+1, 0404+0707+0, FFFF+FCFC+1, FFFF+FFFF+1) with out_ready=1 -> results 1011/0, 0E0F/0, 0B0B/0, FCFC/1, FFFF/1 on 5 consecutive cycles, in order.
- Backpressure: during streaming, drop out_ready for 3 cycles -> in_ready=0, S held constant, no beat lost or duplicated; order is preserved after release.
- Subtract and overflow:
  - 0005-0007, sub=1 -> S=FFFE, cout=0, ovf=0.
  - 7FFF+0001 -> S=8000, ovf=1.
  - 8000-0001, sub=1 -> S=7FFF, cout=1, ovf=1.
- Reset mid-stream: assert rst with 3 beats in flight -> none emerge; the next accepted beat 1234+1111 yields S=2345 after exactly 4 cycles.
